// File: rtl/alu_seq_if.sv
// Start/Busy/Done request bus between the core and the sequential ALU.
interface alu_seq_if #(
  parameter int unsigned W = 8
);
  logic         Start;
  logic [3:0]   OP;
  logic [W-1:0] InputA;
  logic [W-1:0] InputB;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Out;
  logic [W-1:0] ProdHi;
  logic         CarryFlag;
  logic         Halted;

  modport master (
    output Start, OP, InputA, InputB,
    input  Busy, Done, Out, ProdHi, CarryFlag, Halted
  );

  modport slave (
    input  Start, OP, InputA, InputB,
    output Busy, Done, Out, ProdHi, CarryFlag, Halted
  );
endinterface

// File: rtl/alu_seq.sv
// Clocked ALU with carry register, iterative shifts and shift-add multiply.
module alu_seq #(
  parameter int unsigned W = 8
) (
  input logic       Clk,
  input logic       Reset_n,
  alu_seq_if.slave  bus
);
  localparam int unsigned CW = $clog2(W) + 1;
  localparam logic [W-1:0]  WLim = W[W-1:0];
  localparam logic [CW-1:0] CntW = W[CW-1:0];
  localparam logic [CW-1:0] CntOne = CW'(1);

  typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  hi_q, hi_d;
  logic          dir_q, dir_d;
  logic [W-1:0]  out_q, out_d;
  logic [W-1:0]  ph_q, ph_d;
  logic          carry_q, carry_d;
  logic          halted_q, halted_d;
  logic          done_q, done_d;

  logic [W:0]    add_res;
  logic [W-1:0]  diff;
  logic [W:0]    mul_sum;
  logic [W-1:0]  mul_hi;
  logic [W-1:0]  mul_lo;
  logic [W-1:0]  shift_nxt;

  always_comb begin
    add_res   = {1'b0, bus.InputA} + {1'b0, bus.InputB} + {{W{1'b0}}, carry_q};
    diff      = bus.InputA - bus.InputB;
    // One multiply step: conditionally add A into the high half, then shift {carry,hi,lo} right.
    mul_sum   = {1'b0, hi_q} + ({(W + 1){b_q[0]}} & {1'b0, a_q});
    mul_hi    = mul_sum[W:1];
    mul_lo    = {mul_sum[0], b_q[W-1:1]};
    shift_nxt = dir_q ? (a_q >> 1) : (a_q << 1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    dir_d    = dir_q;
    out_d    = out_q;
    ph_d     = ph_q;
    carry_d  = carry_q;
    halted_d = halted_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          done_d = 1'b1;
          unique case (bus.OP)
            4'b0000: {carry_d, out_d} = add_res;
            4'b0001: out_d = diff;
            4'b0010, 4'b0011, 4'b0100, 4'b1100: out_d = bus.InputB;
            4'b0101: out_d = bus.InputA;
            4'b0110: out_d = ~(bus.InputA & bus.InputB);
            4'b0111: out_d = bus.InputA | bus.InputB;
            4'b1000, 4'b1001: begin
              if (bus.InputB == '0) begin
                out_d = bus.InputA;
              end else if (bus.InputB >= WLim) begin
                out_d = '0;
              end else begin
                done_d  = 1'b0;
                state_d = StShift;
                a_d     = bus.InputA;
                dir_d   = bus.OP[0];
                cnt_d   = bus.InputB[CW-1:0];
              end
            end
            4'b1010: carry_d = 1'b0;
            4'b1011: halted_d = 1'b1;
            4'b1101: out_d = {{(W - 1){1'b0}}, diff[W-1]};
            4'b1110: out_d = {{(W - 1){1'b0}}, (bus.InputA == bus.InputB)};
            4'b1111: begin
              done_d  = 1'b0;
              state_d = StMul;
              a_d     = bus.InputA;
              b_d     = bus.InputB;
              hi_d    = '0;
              cnt_d   = CntW;
            end
            default: ;
          endcase
        end
      end
      StShift: begin
        a_d   = shift_nxt;
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          out_d   = shift_nxt;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StMul: begin
        hi_d  = mul_hi;
        b_d   = mul_lo;
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          ph_d    = mul_hi;
          out_d   = mul_lo;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      dir_q    <= 1'b0;
      out_q    <= '0;
      ph_q     <= '0;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      dir_q    <= dir_d;
      out_q    <= out_d;
      ph_q     <= ph_d;
      carry_q  <= carry_d;
      halted_q <= halted_d;
      done_q   <= done_d;
    end
  end

  assign bus.Busy      = (state_q != StIdle);
  assign bus.Done      = done_q;
  assign bus.Out       = out_q;
  assign bus.ProdHi    = ph_q;
  assign bus.CarryFlag = carry_q;
  assign bus.Halted    = halted_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, corner sequences, random vs model.
module tb_alu_seq;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.W(W)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         c;
    logic [W-1:0] ph;
    int           lat;
  } vec_t;

  vec_t tbl[$];

  // Reference state, updated from the opcode rules with plain arithmetic.
  logic [W-1:0] m_out, m_ph;
  logic         m_c, m_h;
  int           m_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] out, input logic c, input logic [W-1:0] ph,
                         input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.out = out; v.c = c; v.ph = ph; v.lat = lat;
    tbl.push_back(v);
  endtask

  // Issues one op now (caller guarantees Busy=0); returns edges from capture until Done seen.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    bus.Start  = 1'b1;
    bus.OP     = op;
    bus.InputA = a;
    bus.InputB = b;
    @(posedge clk);
    #1;
    bus.InputA = W'($urandom);
    bus.InputB = W'($urandom);
    bus.OP     = 4'($urandom);
    bus.Start  = 1'b0;
    lat = 1;
    while (!bus.Done && lat < 40) begin
      bus.Start = bus.Busy ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    bus.Start = 1'b0;
    check("done_seen", 64'(bus.Done), 64'd1);
    check("busy_at_done", 64'(bus.Busy), 64'd0);
  endtask

  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned  n;
    int unsigned  s;
    logic [2*W-1:0] p;
    logic [W-1:0] d;
    n = 32'(b);
    m_lat = 1;
    case (op)
      4'b0000: begin
        s = 32'(a) + 32'(b) + 32'(m_c);
        m_out = s[W-1:0];
        m_c = s[W];
      end
      4'b0001: m_out = a - b;
      4'b0010, 4'b0011, 4'b0100, 4'b1100: m_out = b;
      4'b0101: m_out = a;
      4'b0110: m_out = ~(a & b);
      4'b0111: m_out = a | b;
      4'b1000, 4'b1001: begin
        if (n >= W) m_out = '0;
        else m_out = op[0] ? (a >> n) : (a << n);
        if (n != 0 && n < W) m_lat = int'(n) + 1;
      end
      4'b1010: m_c = 1'b0;
      4'b1011: m_h = 1'b1;
      4'b1101: begin
        d = a - b;
        m_out = (d >= W'(1 << (W - 1))) ? W'(1) : W'(0);
      end
      4'b1110: m_out = (a == b) ? W'(1) : W'(0);
      default: begin
        p = 2*W'(a) * 2*W'(b);
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        m_out = p[W-1:0];
        m_ph = p[2*W-1:W];
        m_lat = W + 1;
      end
    endcase
  endtask

  initial begin
    int lat;
    int dones;
    tests = 0;
    fails = 0;
    bus.Start = 1'b0; bus.OP = '0; bus.InputA = '0; bus.InputB = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    check("rst_out", 64'(bus.Out), 64'd0);
    check("rst_prodhi", 64'(bus.ProdHi), 64'd0);
    check("rst_carry", 64'(bus.CarryFlag), 64'd0);
    check("rst_halted", 64'(bus.Halted), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    //      op       A      B      Out    C     PH     lat
    add_vec(4'b0000, 8'hF0, 8'h20, 8'h10, 1'b1, 8'h00, 1);
    add_vec(4'b0000, 8'h01, 8'h01, 8'h03, 1'b0, 8'h00, 1);
    add_vec(4'b0000, 8'h80, 8'h80, 8'h00, 1'b1, 8'h00, 1);
    add_vec(4'b1010, 8'h12, 8'h34, 8'h00, 1'b0, 8'h00, 1);
    add_vec(4'b0000, 8'h7F, 8'h01, 8'h80, 1'b0, 8'h00, 1);
    add_vec(4'b0001, 8'h10, 8'h20, 8'hF0, 1'b0, 8'h00, 1);
    add_vec(4'b1000, 8'h81, 8'h03, 8'h08, 1'b0, 8'h00, 4);
    add_vec(4'b1001, 8'hA5, 8'h00, 8'hA5, 1'b0, 8'h00, 1);
    add_vec(4'b1000, 8'hFF, 8'h09, 8'h00, 1'b0, 8'h00, 1);
    add_vec(4'b1001, 8'hF0, 8'h04, 8'h0F, 1'b0, 8'h00, 5);
    add_vec(4'b1000, 8'h01, 8'h07, 8'h80, 1'b0, 8'h00, 8);
    add_vec(4'b1001, 8'h80, 8'h08, 8'h00, 1'b0, 8'h00, 1);
    add_vec(4'b1111, 8'd200, 8'd3, 8'h58, 1'b0, 8'h02, 9);
    add_vec(4'b1101, 8'h05, 8'h09, 8'h01, 1'b0, 8'h02, 1);
    add_vec(4'b1101, 8'h09, 8'h05, 8'h00, 1'b0, 8'h02, 1);
    add_vec(4'b1110, 8'h7E, 8'h7E, 8'h01, 1'b0, 8'h02, 1);
    add_vec(4'b1110, 8'h7E, 8'h7F, 8'h00, 1'b0, 8'h02, 1);
    add_vec(4'b0110, 8'hFF, 8'h0F, 8'hF0, 1'b0, 8'h02, 1);
    add_vec(4'b0111, 8'h0F, 8'h30, 8'h3F, 1'b0, 8'h02, 1);
    add_vec(4'b0010, 8'h11, 8'h22, 8'h22, 1'b0, 8'h02, 1);
    add_vec(4'b0011, 8'h11, 8'h33, 8'h33, 1'b0, 8'h02, 1);
    add_vec(4'b0100, 8'h11, 8'h44, 8'h44, 1'b0, 8'h02, 1);
    add_vec(4'b1100, 8'h11, 8'h66, 8'h66, 1'b0, 8'h02, 1);
    add_vec(4'b0101, 8'hAB, 8'h66, 8'hAB, 1'b0, 8'h02, 1);
    add_vec(4'b1111, 8'hFF, 8'hFF, 8'h01, 1'b0, 8'hFE, 9);
    add_vec(4'b0001, 8'h00, 8'h01, 8'hFF, 1'b0, 8'hFE, 1);

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat);
      check($sformatf("v%0d_out", i), 64'(bus.Out), 64'(tbl[i].out));
      check($sformatf("v%0d_carry", i), 64'(bus.CarryFlag), 64'(tbl[i].c));
      check($sformatf("v%0d_prodhi", i), 64'(bus.ProdHi), 64'(tbl[i].ph));
      check($sformatf("v%0d_halted", i), 64'(bus.Halted), 64'd0);
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), 64'(bus.Done), 64'd0);
    end

    // HALT then a MOV issued in the Done cycle.
    run_op(4'b1011, 8'h00, 8'h00, lat);
    check("halt_halted", 64'(bus.Halted), 64'd1);
    check("halt_out", 64'(bus.Out), 64'hFF);
    check("halt_lat", 64'(lat), 64'd1);
    run_op(4'b0010, 8'h00, 8'h55, lat);
    check("b2b_out", 64'(bus.Out), 64'h55);
    check("b2b_lat", 64'(lat), 64'd1);
    check("b2b_halted", 64'(bus.Halted), 64'd1);

    // Abort a MUL with reset after 4 edges.
    run_op(4'b0000, 8'h80, 8'h80, lat);
    bus.Start = 1'b1; bus.OP = 4'b1111; bus.InputA = 8'd200; bus.InputB = 8'd3;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_pre", 64'(bus.Busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.Busy), 64'd0);
    check("abort_done", 64'(bus.Done), 64'd0);
    check("abort_out", 64'(bus.Out), 64'd0);
    check("abort_prodhi", 64'(bus.ProdHi), 64'd0);
    check("abort_carry", 64'(bus.CarryFlag), 64'd0);
    check("abort_halted", 64'(bus.Halted), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.Done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);

    m_out = '0; m_ph = '0; m_c = 1'b0; m_h = 1'b0;
    for (int k = 0; k < 300; k++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom);
      b  = (op[3:1] == 3'b100) ? W'($urandom_range(0, W + 3)) : W'($urandom);
      model(op, a, b);
      run_op(op, a, b, lat);
      check($sformatf("r%0d_out", k), 64'(bus.Out), 64'(m_out));
      check($sformatf("r%0d_carry", k), 64'(bus.CarryFlag), 64'(m_c));
      check($sformatf("r%0d_prodhi", k), 64'(bus.ProdHi), 64'(m_ph));
      check($sformatf("r%0d_halted", k), 64'(bus.Halted), 64'(m_h));
      check($sformatf("r%0d_lat", k), 64'(lat), 64'(m_lat));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
        check($sformatf("r%0d_done_pulse", k), 64'(bus.Done), 64'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
